sel_skid_reg: RTL
=================

Name: sel_skid_reg

Overview:
- Parametrised successor to the 2:1 32-bit word selector.
- Picks one of NUM_IN WIDTH-bit words by index and registers the result into a 2-entry skid buffer with valid/ready handshakes on both sides.
- Used as the registered operand-select stage in the pipelined datapath, for example the forwarding select feeding the EX stage.
- Stalls come from downstream backpressure; bubbles come from flush.

Parameters:
- WIDTH, 32, data word width in bits.
- NUM_IN, 4, number of candidate inputs; must be at least 2.
- RESET_VAL, {WIDTH{1'b0}}, value of out_data after reset and flush.
- SEL_W, derived localparam = max(1, $clog2(NUM_IN)); not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- sel  input  SEL_W  index of the selected input word.
- din  input  NUM_IN*WIDTH  flattened inputs; word i occupies din[i*WIDTH +: WIDTH].
- in_valid  input  1  upstream presents sel/din.
- in_ready  output  1  block can accept a word this cycle.
- flush  input  1  synchronous discard of all buffered and in-flight data.
- out_data  output  WIDTH  head-of-buffer word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- sel_err  output  1  one-cycle pulse: an accepted transfer had sel >= NUM_IN.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to EMPTY.
  - out_valid=0, out_data=RESET_VAL, in_ready=0, sel_err=0.
  - in_ready rises at the first clk edge after rst_n deasserts.
- Selection:
  - Word = din[sel*WIDTH +: WIDTH].
  - If sel >= NUM_IN, the stored word is RESET_VAL and sel_err pulses high in the cycle after the accept.
- Transfers:
  - Accept = in_valid && in_ready.
  - Issue = out_valid && out_ready.
  - All outputs are registered; no combinational path from in_valid/din to out_*, or from out_ready to in_ready.
- Latency: a word accepted at edge N appears on out_data with out_valid=1 after edge N, i.e. one cycle, when the buffer was EMPTY.
- Throughput: one word per cycle sustained while out_ready=1.
- States (occupancy):
  - EMPTY: out_valid=0, in_ready=1. Accept -> ONE.
  - ONE: out_valid=1, in_ready=1.
    - Accept without issue -> FULL; the new word goes to the skid slot.
    - Issue without accept -> EMPTY.
    - Accept with issue -> stay ONE; the new word becomes head.
  - FULL: out_valid=1, in_ready=0. Issue -> ONE; the skid word moves to head in the same edge.
- Ordering: strict FIFO order; no word is dropped or duplicated except by flush.
- Stall: out_ready=0 holds out_data and out_valid stable until issue.
- flush (priority over accept and issue in the same cycle):
  - Next state EMPTY; out_valid=0; out_data=RESET_VAL.
  - A word offered in the flush cycle is discarded and raises no sel_err.
  - in_ready=1 in the following cycle.
- rst_n asserted mid-transfer: all content is lost immediately; no partial word is ever presented.
- Unused out_data bits are never X after reset.

Decomposition:
- Shared datapath package holds:
  - occupancy state encoding: EMPTY=2'd0, ONE=2'd1, FULL=2'd2.
  - default WIDTH=32 constant, shared with the existing selectors.
- Natural sub-module: sel_n_word.
  - Purely combinational NUM_IN:1 WIDTH-bit selector with an out-of-range flag.
  - Instantiated once; the 2-entry buffer and FSM stay in sel_skid_reg.

Test Plan:
1. Reset/idle: hold rst_n=0 for 3 cycles, release -> out_valid=0, out_data=0, sel_err=0; in_ready=1 from the 1st edge after release.
2. Streaming: din words 0x11111111/0x22222222/0x33333333/0x44444444, sel=2, in_valid=1, out_ready=1 -> out_data=0x33333333 one cycle later; sel sequence 0,1,3 gives 0x11111111, 0x22222222, 0x44444444 on consecutive cycles.
3. Backpressure:
   - Setup: out_ready=0, sel=1 then sel=3 accepted.
   - Expect FULL, in_ready=0, out_data=0x22222222 held.
   - Then out_ready=1 -> 0x22222222 then 0x44444444 in order; in_ready=1 one cycle after the first issue.
4. Out-of-range (NUM_IN=3, SEL_W=2): accepted transfer with sel=3 -> out_data=RESET_VAL, sel_err=1 for exactly one cycle.
5. Flush in FULL with simultaneous in_valid=1 and out_ready=1 -> next cycle out_valid=0, out_data=RESET_VAL, in_ready=1; the offered word is never output.
6. Async reset mid-stream: drop rst_n between edges while in ONE -> out_valid=0 immediately, without waiting for a clk edge; after release, the stream from test 2 works unchanged.

Source files
------------

// File: rtl/sel_skid_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sel_skid_reg_pkg
//  Description : Shared datapath definitions for the registered operand-select
//                stage: buffer occupancy encoding, default word width and the
//                select-index width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package sel_skid_reg_pkg;

    // Default datapath word width, common to every selector in the datapath.
    localparam int c_default_width = 32;

    // Occupancy of the 2-entry skid buffer.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_state_t;

    // Select index width for n candidates; never narrower than one bit.
    function automatic int sel_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : sel_skid_reg_pkg
`default_nettype wire

// File: rtl/sel_skid_reg_sel_n_word.sv
`default_nettype none
// ============================================================================
//  Module      : sel_n_word
//  Description : Combinational NUM_IN:1 selector of WIDTH-bit words with an
//                out-of-range flag. An index with no matching word yields
//                RESET_VAL so nothing undefined ever leaves the selector.
//  Revision    : 1.0  initial release
// ============================================================================
module sel_n_word
    import sel_skid_reg_pkg::*;
#(
    parameter int                 WIDTH     = c_default_width,
    parameter int                 NUM_IN    = 4,
    parameter int                 SEL_W     = 2,
    parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic [SEL_W-1:0]        i_sel,
    input  logic [NUM_IN*WIDTH-1:0] i_din,
    output logic [WIDTH-1:0]        o_word,
    output logic                    o_oor
);

    logic [WIDTH-1:0] w_words [NUM_IN];

    // Split the flattened input bus into individual candidate words.
    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_unpack
            assign w_words[gi] = i_din[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Match the index against every legal candidate; no match means out of range.
    always_comb begin
        o_word = RESET_VAL;
        o_oor  = 1'b1;
        for (int i = 0; i < NUM_IN; i++) begin
            if (i_sel == SEL_W'(i)) begin
                o_word = w_words[i];
                o_oor  = 1'b0;
            end
        end
    end

endmodule : sel_n_word
`default_nettype wire

// File: rtl/sel_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module      : sel_skid_reg
//  Description : Registered operand-select stage. Picks one of NUM_IN words by
//                index and holds it in a 2-entry skid buffer with valid/ready
//                on both sides. Every output comes straight from a flop, so
//                neither in_valid/din nor out_ready reach an output through
//                logic. flush empties the buffer and drops the offered word.
//  Revision    : 1.0  initial release
// ============================================================================
module sel_skid_reg
    import sel_skid_reg_pkg::*;
#(
    parameter int               WIDTH     = c_default_width,
    parameter int               NUM_IN    = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [sel_width(NUM_IN)-1:0]  sel,
    input  logic [NUM_IN*WIDTH-1:0]       din,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          flush,
    output logic [WIDTH-1:0]              out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          sel_err
);

    localparam int SEL_W = sel_width(NUM_IN);

    occ_state_t       r_state;
    occ_state_t       w_state_nxt;

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_skid;
    logic             r_out_valid;
    logic             r_in_ready;
    logic             r_sel_err;

    logic [WIDTH-1:0] w_sel_word;
    logic             w_sel_oor;
    logic             w_accept;
    logic             w_issue;
    logic             w_load_head_new;
    logic             w_load_head_skid;
    logic             w_load_skid;
    logic             w_clear;

    sel_n_word #(
        .WIDTH     (WIDTH),
        .NUM_IN    (NUM_IN),
        .SEL_W     (SEL_W),
        .RESET_VAL (RESET_VAL)
    ) u_sel (
        .i_sel  (sel),
        .i_din  (din),
        .o_word (w_sel_word),
        .o_oor  (w_sel_oor)
    );

    // Handshakes are qualified only by registered flags.
    assign w_accept = in_valid && r_in_ready;
    assign w_issue  = r_out_valid && out_ready;

    // Occupancy transitions and buffer-move controls; flush overrides everything.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_head_new  = 1'b0;
        w_load_head_skid = 1'b0;
        w_load_skid      = 1'b0;
        w_clear          = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_clear     = 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt     = ST_ONE;
                        w_load_head_new = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_issue) begin
                        // Head leaves and the new word replaces it directly.
                        w_load_head_new = 1'b1;
                    end else if (w_accept) begin
                        // Head is stalled; park the new word behind it.
                        w_state_nxt = ST_FULL;
                        w_load_skid = 1'b1;
                    end else if (w_issue) begin
                        w_state_nxt = ST_EMPTY;
                        w_clear     = 1'b1;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only an issue can happen.
                    if (w_issue) begin
                        w_state_nxt      = ST_ONE;
                        w_load_head_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                    w_clear     = 1'b1;
                end
            endcase
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered handshake flags and the out-of-range pulse, derived from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
            r_sel_err   <= 1'b0;
        end else begin
            r_out_valid <= (w_state_nxt != ST_EMPTY);
            r_in_ready  <= (w_state_nxt != ST_FULL);
            r_sel_err   <= w_accept && w_sel_oor && !flush;
        end
    end

    // Head and skid word storage; emptied slots return to RESET_VAL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= RESET_VAL;
            r_skid <= RESET_VAL;
        end else begin
            if (w_clear) begin
                r_head <= RESET_VAL;
                r_skid <= RESET_VAL;
            end else begin
                if (w_load_head_new) begin
                    r_head <= w_sel_word;
                end else if (w_load_head_skid) begin
                    r_head <= r_skid;
                end
                if (w_load_skid) begin
                    r_skid <= w_sel_word;
                end
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_head;
    assign sel_err   = r_sel_err;

endmodule : sel_skid_reg
`default_nettype wire
